// File: rtl/imm_ext_stage.sv
// Registered immediate-extraction stage: decodes and extends the immediate
// field of an ARMv8 instruction by encoding class, holds it in a
// single-entry valid/ready pipeline register, and counts illegal entries.
module imm_ext_stage #(
  parameter int XLEN     = 64,
  parameter int TAG_W    = 5,
  parameter int SCALE_BR = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       sign_ext,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] tag_out,
  output logic             imm_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] MODE_ALU   = 3'b000;
  localparam logic [2:0] MODE_DT    = 3'b001;
  localparam logic [2:0] MODE_SHAMT = 3'b010;
  localparam logic [2:0] MODE_CB    = 3'b011;
  localparam logic [2:0] MODE_B     = 3'b100;
  localparam logic [2:0] MODE_MOVW  = 3'b101;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Branch offsets are word offsets; optionally convert them to bytes.
  function automatic logic signed [XLEN-1:0] scale_br(input logic signed [XLEN-1:0] v);
    return (SCALE_BR != 0) ? (v <<< 2) : v;
  endfunction

  logic signed [XLEN-1:0] sx_dt;
  logic signed [XLEN-1:0] sx_cb;
  logic signed [XLEN-1:0] sx_b;
  logic [XLEN-1:0]        zx_alu;
  logic [XLEN-1:0]        zx_shamt;
  logic [XLEN-1:0]        zx_movw;
  logic [5:0]             movw_sh;
  logic [XLEN-1:0]        dec_imm;
  logic                   dec_err;
  logic                   accept;

  logic                   vld_p1;
  logic [XLEN-1:0]        imm_p1;
  logic [TAG_W-1:0]       tag_p1;
  logic                   err_p1;
  logic [CNT_W-1:0]       cnt_p1;

  // Opcode/condition bits above the widest field are never looked at.
  logic unused_bits;
  assign unused_bits = ^instr[31:26];

  // Field extraction and extension; sign is taken from the field MSB before scaling.
  always_comb begin
    sx_dt    = {{(XLEN-9){instr[20]}}, instr[20:12]};
    sx_cb    = {{(XLEN-19){instr[23]}}, instr[23:5]};
    sx_b     = {{(XLEN-26){instr[25]}}, instr[25:0]};
    zx_alu   = {{(XLEN-12){1'b0}}, instr[21:10]};
    zx_shamt = {{(XLEN-6){1'b0}}, instr[15:10]};
    movw_sh  = {instr[22:21], 4'b0000};
    zx_movw  = {{(XLEN-16){1'b0}}, instr[20:5]} << movw_sh;
  end

  // Mode select; anything not recognised yields the illegal result.
  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (sign_ext)
      MODE_ALU:   dec_imm = instr[22] ? (zx_alu << 12) : zx_alu;
      MODE_DT:    dec_imm = sx_dt;
      MODE_SHAMT: dec_imm = zx_shamt;
      MODE_CB:    dec_imm = scale_br(sx_cb);
      MODE_B:     dec_imm = scale_br(sx_b);
      MODE_MOVW: begin
        // A 32-bit datapath only has half-words 0 and 1.
        if (XLEN == 32 && instr[22]) dec_err = 1'b1;
        else                         dec_imm = zx_movw;
      end
      default:    dec_err = 1'b1;
    endcase
  end

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // ---- stage p1: output register and illegal-entry counter ----
  // Flush dominates any accept or drain; data holds whenever nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      imm_p1 <= '0;
      tag_p1 <= '0;
      err_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      imm_p1 <= dec_imm;
      tag_p1 <= tag_in;
      err_p1 <= dec_err;
      if (dec_err) cnt_p1 <= sat_inc(cnt_p1);
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign imm       = imm_p1;
  assign tag_out   = tag_p1;
  assign imm_err   = err_p1;
  assign err_count = cnt_p1;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: three instances (64-bit scaled, 64-bit unscaled,
// 32-bit scaled) driven in lockstep, checked against a queue of expected
// results computed by an arithmetic reference model.
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  sign_ext;
  logic [4:0]  tag_in;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, imm_err;
  logic [63:0] imm;
  logic [4:0]  tag_out;
  logic [7:0]  err_count;

  logic        in_ready0, out_valid0, imm_err0;
  logic [63:0] imm0;
  logic [4:0]  tag_out0;
  logic [7:0]  err_count0;

  logic        in_ready32, out_valid32, imm_err32;
  logic [31:0] imm32;
  logic [4:0]  tag_out32;
  logic [7:0]  err_count32;

  always #5 clk = ~clk;

  imm_ext_stage #(.XLEN(64), .TAG_W(5), .SCALE_BR(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .sign_ext(sign_ext), .tag_in(tag_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .imm(imm),
    .tag_out(tag_out), .imm_err(imm_err), .err_count(err_count));

  imm_ext_stage #(.XLEN(64), .TAG_W(5), .SCALE_BR(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .instr(instr), .sign_ext(sign_ext), .tag_in(tag_in), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .imm(imm0),
    .tag_out(tag_out0), .imm_err(imm_err0), .err_count(err_count0));

  imm_ext_stage #(.XLEN(32), .TAG_W(5), .SCALE_BR(1), .CNT_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .sign_ext(sign_ext), .tag_in(tag_in), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32),
    .tag_out(tag_out32), .imm_err(imm_err32), .err_count(err_count32));

  typedef struct {
    logic [63:0] imm;
    logic [63:0] imm0;
    logic [63:0] imm32;
    logic [4:0]  tag;
    logic        err;
    logic        err32;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  int exp_cnt = 0;
  int exp_cnt32 = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Arithmetic reference: fields as integers, scaling as multiplication.
  function automatic void ref_model(input int xl, input bit scale, input logic [31:0] ins,
                                    input logic [2:0] mode, output logic [63:0] v,
                                    output logic err);
    longint s;
    err = 1'b0;
    s   = 0;
    case (mode)
      3'd0: s = longint'(ins[21:10]) * (ins[22] ? 4096 : 1);
      3'd1: begin s = longint'(ins[20:12]); if (ins[20]) s -= 512; end
      3'd2: s = longint'(ins[15:10]);
      3'd3: begin s = longint'(ins[23:5]); if (ins[23]) s -= (64'sd1 <<< 19); if (scale) s *= 4; end
      3'd4: begin s = longint'(ins[25:0]); if (ins[25]) s -= (64'sd1 <<< 26); if (scale) s *= 4; end
      3'd5: begin
        s = longint'(ins[20:5]) * (64'sd1 <<< (16 * ins[22:21]));
        if (xl == 32 && ins[22]) err = 1'b1;
      end
      default: err = 1'b1;
    endcase
    v = err ? 64'd0 : s;
    if (xl == 32) v[63:32] = 32'd0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] m,
                       input logic [4:0] t, input logic ordy, input logic fl);
    in_valid  = v;
    instr     = ins;
    sign_ext  = m;
    tag_in    = t;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: check handshake and any consumed entry, update the model, cross the edge.
  task automatic tick();
    exp_t e;
    logic rdy;
    #1;
    rdy = (q.size() == 0) || out_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("err_count", {56'd0, err_count}, 64'(exp_cnt));
    chk("err_count32", {56'd0, err_count32}, 64'(exp_cnt32));
    if (q.size() != 0 && out_ready) begin
      e = q.pop_front();
      n_out++;
      chk("imm", imm, e.imm);
      chk("tag_out", {59'd0, tag_out}, {59'd0, e.tag});
      chk("imm_err", {63'd0, imm_err}, {63'd0, e.err});
      chk("imm_s0", imm0, e.imm0);
      chk("imm_x32", {32'd0, imm32}, e.imm32);
      chk("imm_err_x32", {63'd0, imm_err32}, {63'd0, e.err32});
    end
    if (flush) begin
      q.delete();
    end else if (in_valid && rdy) begin
      ref_model(64, 1'b1, instr, sign_ext, e.imm, e.err);
      ref_model(64, 1'b0, instr, sign_ext, e.imm0, e.err);
      ref_model(32, 1'b1, instr, sign_ext, e.imm32, e.err32);
      e.tag = tag_in;
      q.push_back(e);
      if (e.err && exp_cnt < 255) exp_cnt++;
      if (e.err32 && exp_cnt32 < 255) exp_cnt32++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_tag", {59'd0, tag_out}, 64'd0);
    chk("rst_imm_err", {63'd0, imm_err}, 64'd0);
    chk("rst_err_count", {56'd0, err_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU with and without LSL #12
    drive(1'b1, (32'hFFF << 10) | (32'd1 << 22), 3'd0, 5'd1, 1'b1, 1'b0);
    tick();
    #1 chk("alu_lsl", imm, 64'h0000_0000_00FF_F000);
    drive(1'b1, (32'hFFF << 10), 3'd0, 5'd2, 1'b1, 1'b0);
    tick();
    #1 chk("alu_raw", imm, 64'h0000_0000_0000_0FFF);

    // DT and CB sign extension, scaled and unscaled
    drive(1'b1, (32'h1F0 << 12), 3'd1, 5'd3, 1'b1, 1'b0);
    tick();
    #1 chk("dt_neg", imm, 64'hFFFF_FFFF_FFFF_FFF0);
    drive(1'b1, (32'h7FFFF << 5), 3'd3, 5'd4, 1'b1, 1'b0);
    tick();
    #1 chk("cb_scaled", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("cb_unscaled", imm0, 64'hFFFF_FFFF_FFFF_FFFF);

    // MOVW hw=2 is illegal only on the 32-bit instance
    drive(1'b1, (32'hBEEF << 5) | (32'd2 << 21), 3'd5, 5'd5, 1'b1, 1'b0);
    tick();
    #1 chk("movw32_imm", {32'd0, imm32}, 64'd0);
    chk("movw32_err", {63'd0, imm_err32}, 64'd1);
    chk("movw32_cnt", {56'd0, err_count32}, 64'd1);
    chk("movw64_hw2", imm, 64'h0000_BEEF_0000_0000);
    drive(1'b1, (32'hBEEF << 5) | (32'd3 << 21), 3'd5, 5'd6, 1'b1, 1'b0);
    tick();
    #1 chk("movw_hw3", imm, 64'hBEEF_0000_0000_0000);
    drive(1'b1, 32'h0200_0000, 3'd4, 5'd7, 1'b1, 1'b0);
    tick();
    #1 chk("b_neg", imm, 64'hFFFF_FFFF_F800_0000);

    // Backpressure: A (tag 5) held while B waits
    drive(1'b1, (32'h3F << 10), 3'd2, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, (32'h15 << 10), 3'd2, 5'd9, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_tag", {59'd0, tag_out}, 64'd5);
      chk("bp_imm", imm, 64'd63);
    end
    drive(1'b1, (32'h15 << 10), 3'd2, 5'd9, 1'b1, 1'b0);
    tick();
    #1 chk("bp_b_tag", {59'd0, tag_out}, 64'd9);
    chk("bp_b_imm", imm, 64'h15);
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    tick();

    // Streaming: one result per cycle
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, $urandom, 3'($urandom_range(0, 5)), 5'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    tick();
    chk("stream_count", 64'(n_out), 64'd8);

    // Flush kills the held entry and an incoming illegal one
    drive(1'b1, (32'h0AB << 10), 3'd0, 5'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd0, 3'b110, 5'd4, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    #1 chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_cnt", {56'd0, err_count}, 64'd0);
    tick();

    // Saturation of the illegal-entry counter
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, $urandom, (i % 2 == 0) ? 3'b110 : 3'b111, 5'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    tick();
    chk("sat_cnt", {56'd0, err_count}, 64'd255);
    chk("sat_cnt32", {56'd0, err_count32}, 64'd255);

    // Asynchronous reset while an entry is held
    drive(1'b1, (32'h456 << 10), 3'd0, 5'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_imm", imm, 64'd0);
    chk("arst_tag", {59'd0, tag_out}, 64'd0);
    chk("arst_imm_err", {63'd0, imm_err}, 64'd0);
    chk("arst_cnt", {56'd0, err_count}, 64'd0);
    q.delete();
    exp_cnt   = 0;
    exp_cnt32 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, (32'h123 << 10), 3'd0, 5'd6, 1'b1, 1'b0);
    tick();
    #1 chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_imm", imm, 64'h123);
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
